wb_rr_arbiter: RTL and testbench



---
 rtl/wb_rr_arbiter_if.sv | 41 ++++
 rtl/wb_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Signal bundle for wb_rr_arbiter: NM pipelined Wishbone master ports plus the shared slave port.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface wb_rr_arbiter_if #(
  parameter int NM = 2,
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [NM-1:0]    i_m_cyc;
  logic [NM-1:0]    i_m_stb;
  logic [NM-1:0]    i_m_we;
  logic [NM*AW-1:0] i_m_addr;
  logic [NM*DW-1:0] i_m_data;
  logic [NM-1:0]    o_m_stall;
  logic [NM-1:0]    o_m_ack;
  logic [NM-1:0]    o_m_err;
  logic [DW-1:0]    o_m_data;

  logic             o_wb_cyc;
  logic             o_wb_stb;
  logic             o_wb_we;
  logic [AW-1:0]    o_wb_addr;
  logic [DW-1:0]    o_wb_data;
  logic             i_wb_stall;
  logic             i_wb_ack;
  logic             i_wb_err;
  logic [DW-1:0]    i_wb_data;

  modport slave (
    input  i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data,
    output o_m_stall, o_m_ack, o_m_err, o_m_data,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
  );

  modport master (
    output i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data,
    input  o_m_stall, o_m_ack, o_m_err, o_m_data,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between NM masters, with
// outstanding-transaction tracking so responses reach only the owner, and a hung-cycle watchdog.
module wb_rr_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int LGOUT   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  wb_rr_arbiter_if.slave bus
);

  localparam int GW = $clog2(NM);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t           state, state_nxt;
  logic [GW-1:0]    grant, grant_nxt;
  logic [GW-1:0]    last_grant, last_grant_nxt;
  logic [LGOUT-1:0] cnt, cnt_nxt;
  logic [TW-1:0]    timer, timer_nxt;

  logic          own;
  logic          cyc_g;
  logic          full;
  logic          cnt_nz;
  logic          wb_stb;
  logic          accept;
  logic          resp;
  logic          pending;
  logic          wd_fire;
  logic [GW-1:0] rr_pick;
  logic [GW-1:0] rr_idx;
  logic          rr_found;

  always_comb begin
    own     = (state == OWN);
    cyc_g   = bus.i_m_cyc[grant];
    full    = &cnt;
    cnt_nz  = |cnt;
    wb_stb  = own & cyc_g & bus.i_m_stb[grant] & ~full;
    accept  = wb_stb & ~bus.i_wb_stall;
    resp    = bus.i_wb_ack | bus.i_wb_err;
    pending = cnt_nz | wb_stb;
    wd_fire = own & cyc_g & pending & ~resp & ~accept & (timer == TIMER_LAST);
  end

  // Search starts just after the previous winner, so every requester is reached within NM grants.
  always_comb begin
    rr_pick  = last_grant;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      rr_idx = GW'((int'(last_grant) + k) % NM);
      if (!rr_found && bus.i_m_cyc[rr_idx]) begin
        rr_pick  = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    timer_nxt      = timer;
    case (state)
      IDLE: begin
        cnt_nxt   = '0;
        timer_nxt = '0;
        if (|bus.i_m_cyc) begin
          grant_nxt      = rr_pick;
          last_grant_nxt = rr_pick;
          state_nxt      = OWN;
        end
      end
      OWN: begin
        if (!cyc_g) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          timer_nxt = '0;
        end else if (wd_fire) begin
          state_nxt = ABORT;
          cnt_nxt   = '0;
          timer_nxt = '0;
        end else begin
          if (accept && !(resp && cnt_nz)) begin
            cnt_nxt = cnt + LGOUT'(1);
          end else if (!accept && resp && cnt_nz) begin
            cnt_nxt = cnt - LGOUT'(1);
          end
          if (resp || accept) begin
            timer_nxt = '0;
          end else if (pending) begin
            timer_nxt = timer + TW'(1);
          end
        end
      end
      ABORT: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        timer_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        timer_nxt = '0;
      end
    endcase
  end

  // Only the owner ever sees its stall drop or receives a response.
  always_comb begin
    bus.o_wb_cyc  = own & cyc_g;
    bus.o_wb_stb  = wb_stb;
    bus.o_wb_we   = bus.i_m_we[grant];
    bus.o_wb_addr = bus.i_m_addr[int'(grant)*AW +: AW];
    bus.o_wb_data = bus.i_m_data[int'(grant)*DW +: DW];
    bus.o_m_data  = bus.i_wb_data;
    bus.o_m_stall = '1;
    bus.o_m_ack   = '0;
    bus.o_m_err   = '0;
    if (own) begin
      bus.o_m_stall[grant] = bus.i_wb_stall | full;
      bus.o_m_ack[grant]   = bus.i_wb_ack & cnt_nz;
      bus.o_m_err[grant]   = (bus.i_wb_err & cnt_nz) | wd_fire;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NM - 1);
      cnt        <= '0;
      timer      <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      timer      <= timer_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios followed by random traffic, every cycle compared
// against a transaction-level reference model built from a queue of outstanding requests.
module tb_wb_rr_arbiter;

  localparam int NM      = 2;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int LGOUT   = 3;
  localparam int TIMEOUT = 64;
  localparam int OUT_MAX = (1 << LGOUT) - 1;
  localparam int ST_IDLE  = 0;
  localparam int ST_OWN   = 1;
  localparam int ST_ABORT = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic [AW-1:0] m_addr [NM];
  logic [DW-1:0] m_data [NM];

  wb_rr_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(
    .NM(NM), .AW(AW), .DW(DW), .LGOUT(LGOUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.i_m_addr = '0;
    bus.i_m_data = '0;
    for (int k = 0; k < NM; k++) begin
      bus.i_m_addr[k*AW +: AW] = m_addr[k];
      bus.i_m_data[k*DW +: DW] = m_data[k];
    end
  end

  int assert_count = 0;
  int fail_count   = 0;

  // Reference model: who owns the bus, a queue of accepted-but-unanswered requests, and the
  // number of cycles the owner has waited without any progress.
  int md_state;
  int md_owner;
  int md_last;
  int md_pend [$];
  int md_age;

  logic          exp_cyc, exp_stb, exp_accept, exp_progress, exp_wd;
  logic [NM-1:0] exp_stall, exp_ack, exp_err;

  logic [NM-1:0] s_stall;
  logic          s_wb_cyc;
  logic [AW-1:0] s_wb_addr;
  int            ack_log [$];
  int            err_log [$];
  int            accept_cnt;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_state = ST_IDLE;
    md_owner = 0;
    md_last  = NM - 1;
    md_pend.delete();
    md_age   = 0;
  endtask

  task automatic model_expect();
    bit own;
    bit req;
    int depth;
    bit full;
    own   = (md_state == ST_OWN);
    req   = own && bus.i_m_cyc[md_owner];
    depth = md_pend.size();
    full  = (depth == OUT_MAX);
    exp_cyc      = req;
    exp_stb      = req && bus.i_m_stb[md_owner] && !full;
    exp_accept   = exp_stb && !bus.i_wb_stall;
    exp_progress = bus.i_wb_ack || bus.i_wb_err || exp_accept;
    exp_wd       = req && (depth != 0 || exp_stb) && !exp_progress && (md_age == TIMEOUT - 1);
    exp_stall = '1;
    exp_ack   = '0;
    exp_err   = '0;
    if (own) begin
      exp_stall[md_owner] = bus.i_wb_stall || full;
      exp_ack[md_owner]   = bus.i_wb_ack && depth != 0;
      exp_err[md_owner]   = (bus.i_wb_err && depth != 0) || exp_wd;
    end
  endtask

  task automatic model_update();
    bit had_pend;
    bit found;
    if (!reset_n) begin
      model_reset();
    end else if (md_state == ST_IDLE) begin
      if (|bus.i_m_cyc) begin
        found = 0;
        for (int k = 1; k <= NM; k++) begin
          if (!found && bus.i_m_cyc[(md_last + k) % NM]) begin
            md_owner = (md_last + k) % NM;
            found    = 1;
          end
        end
        md_last  = md_owner;
        md_state = ST_OWN;
      end
      md_pend.delete();
      md_age = 0;
    end else if (md_state == ST_OWN) begin
      if (!exp_cyc) begin
        md_state = ST_IDLE;
        md_pend.delete();
        md_age = 0;
      end else if (exp_wd) begin
        md_state = ST_ABORT;
        md_pend.delete();
        md_age = 0;
      end else begin
        had_pend = (md_pend.size() != 0);
        if (exp_accept) md_pend.push_back(md_owner);
        if ((bus.i_wb_ack || bus.i_wb_err) && had_pend) void'(md_pend.pop_front());
        if (exp_progress) md_age = 0;
        else if (had_pend || exp_stb) md_age++;
      end
    end else begin
      md_state = ST_IDLE;
      md_pend.delete();
      md_age = 0;
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_expect();
      checkOutput("wb_cyc", bus.o_wb_cyc, exp_cyc);
      checkOutput("wb_stb", bus.o_wb_stb, exp_stb);
      checkOutput("m_stall", bus.o_m_stall, exp_stall);
      checkOutput("m_ack", bus.o_m_ack, exp_ack);
      checkOutput("m_err", bus.o_m_err, exp_err);
      checkOutput("m_data", bus.o_m_data, bus.i_wb_data);
      if (exp_cyc) begin
        checkOutput("wb_we", bus.o_wb_we, bus.i_m_we[md_owner]);
        checkOutput("wb_addr", bus.o_wb_addr, m_addr[md_owner]);
        checkOutput("wb_data", bus.o_wb_data, m_data[md_owner]);
      end
      s_stall   = bus.o_m_stall;
      s_wb_cyc  = bus.o_wb_cyc;
      s_wb_addr = bus.o_wb_addr;
      for (int k = 0; k < NM; k++) begin
        if (bus.o_m_ack[k] === 1'b1) ack_log.push_back(k);
        if (bus.o_m_err[k] === 1'b1) err_log.push_back(k);
      end
      if (bus.o_wb_stb === 1'b1 && !bus.i_wb_stall) accept_cnt++;
      @(posedge clk);
      model_update();
      #1;
    end
  endtask

  // Random masters hold a stalled request unchanged; the slave answers at random.
  task automatic applyStimulus();
    int r;
    for (int k = 0; k < NM; k++) begin
      r = $urandom_range(0, 99);
      if (bus.i_m_cyc[k] && bus.i_m_stb[k] && s_stall[k]) begin
        if (r < 3) begin
          bus.i_m_cyc[k] = 1'b0;
          bus.i_m_stb[k] = 1'b0;
        end
      end else if (!bus.i_m_cyc[k]) begin
        if (r < 30) begin
          bus.i_m_cyc[k] = 1'b1;
          bus.i_m_stb[k] = (r < 20);
          bus.i_m_we[k]  = 1'($urandom_range(0, 1));
          m_addr[k] = AW'($urandom);
          m_data[k] = $urandom;
        end
      end else if (r < 8) begin
        bus.i_m_cyc[k] = 1'b0;
        bus.i_m_stb[k] = 1'b0;
      end else begin
        bus.i_m_stb[k] = (r < 60);
        bus.i_m_we[k]  = 1'($urandom_range(0, 1));
        m_addr[k] = AW'($urandom);
        m_data[k] = $urandom;
      end
    end
    bus.i_wb_stall = ($urandom_range(0, 99) < 30);
    r = $urandom_range(0, 99);
    bus.i_wb_ack  = (r < 35);
    bus.i_wb_err  = (r >= 35 && r < 40);
    bus.i_wb_data = $urandom;
    reset_n = ($urandom_range(0, 599) != 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, %0d failures so far", fail_count);
    $fatal(1);
  end

  initial begin
    int g;
    reset_n        = 1'b0;
    bus.i_m_cyc    = '0;
    bus.i_m_stb    = '0;
    bus.i_m_we     = '0;
    bus.i_wb_stall = 1'b0;
    bus.i_wb_ack   = 1'b0;
    bus.i_wb_err   = 1'b0;
    bus.i_wb_data  = '0;
    for (int k = 0; k < NM; k++) begin
      m_addr[k] = '0;
      m_data[k] = '0;
    end
    s_stall    = '1;
    accept_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    tick(2);

    $display("[TB] single master write with two stall cycles");
    bus.i_m_cyc[0] = 1'b1;
    bus.i_m_stb[0] = 1'b1;
    bus.i_m_we[0]  = 1'b1;
    m_addr[0] = 8'h10;
    m_data[0] = 32'hCAFE_0001;
    bus.i_wb_stall = 1'b1;
    ack_log.delete();
    tick(1);
    tick(2);
    checkOutput("single_held_addr", s_wb_addr, 8'h10);
    bus.i_wb_stall = 1'b0;
    tick(1);
    bus.i_m_stb[0] = 1'b0;
    bus.i_wb_ack   = 1'b1;
    bus.i_wb_data  = 32'h1234_5678;
    tick(1);
    bus.i_wb_ack   = 1'b0;
    bus.i_m_cyc[0] = 1'b0;
    tick(2);
    checkOutput("single_ack_count", ack_log.size(), 1);

    $display("[TB] two masters alternate after reset");
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    bus.i_m_cyc = '1;
    bus.i_m_stb = '1;
    bus.i_m_we  = '0;
    m_addr[0] = 8'h20;
    m_addr[1] = 8'h21;
    ack_log.delete();
    tick(1);
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      tick(1);
      bus.i_m_stb[g] = 1'b0;
      bus.i_wb_ack   = 1'b1;
      tick(1);
      bus.i_wb_ack   = 1'b0;
      bus.i_m_cyc[g] = 1'b0;
      tick(1);
      bus.i_m_cyc[g] = 1'b1;
      bus.i_m_stb[g] = 1'b1;
      tick(1);
    end
    checkOutput("alt_ack_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput("alt_ack_order", ack_log[i], i % 2);
    bus.i_m_cyc = '0;
    bus.i_m_stb = '0;
    tick(2);

    $display("[TB] outstanding limit");
    bus.i_m_cyc[0] = 1'b1;
    bus.i_m_stb[0] = 1'b1;
    bus.i_m_we[0]  = 1'b1;
    m_addr[0] = 8'h30;
    accept_cnt = 0;
    tick(1);
    tick(8);
    checkOutput("full_accepts", accept_cnt, 7);
    checkOutput("full_stall", s_stall[0], 1'b1);
    bus.i_wb_ack = 1'b1;
    tick(1);
    bus.i_wb_ack = 1'b0;
    tick(1);
    checkOutput("full_resume", accept_cnt, 8);
    bus.i_m_stb[0] = 1'b0;
    ack_log.delete();
    bus.i_wb_ack = 1'b1;
    tick(6);
    bus.i_wb_ack   = 1'b0;
    bus.i_m_cyc[0] = 1'b0;
    tick(1);
    bus.i_wb_ack = 1'b1;
    tick(1);
    bus.i_wb_ack   = 1'b0;
    bus.i_m_cyc[0] = 1'b1;
    tick(1);
    bus.i_wb_ack = 1'b1;
    tick(1);
    bus.i_wb_ack   = 1'b0;
    bus.i_m_cyc[0] = 1'b0;
    tick(2);
    checkOutput("drop_ack_count", ack_log.size(), 6);

    $display("[TB] watchdog abort");
    bus.i_m_cyc = '1;
    bus.i_m_stb = '1;
    m_addr[0] = 8'h40;
    m_addr[1] = 8'h41;
    bus.i_wb_stall = 1'b1;
    err_log.delete();
    for (int i = 0; i < TIMEOUT + 4 && err_log.size() == 0; i++) tick(1);
    checkOutput("wd_err_count", err_log.size(), 1);
    checkOutput("wd_err_owner", err_log[0], 1);
    tick(1);
    checkOutput("wd_abort_cyc", s_wb_cyc, 1'b0);
    tick(2);
    checkOutput("wd_next_cyc", s_wb_cyc, 1'b1);
    checkOutput("wd_next_owner", s_wb_addr, 8'h40);
    bus.i_m_cyc = '0;
    bus.i_m_stb = '0;
    bus.i_wb_stall = 1'b0;
    tick(2);

    $display("[TB] reset with requests outstanding");
    bus.i_m_cyc[0] = 1'b1;
    bus.i_m_stb[0] = 1'b1;
    m_addr[0] = 8'h50;
    m_addr[1] = 8'h51;
    tick(4);
    bus.i_m_stb[0] = 1'b0;
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    bus.i_m_cyc = '1;
    bus.i_m_stb = '1;
    tick(1);
    checkOutput("rst_cyc_low", s_wb_cyc, 1'b0);
    ack_log.delete();
    bus.i_wb_ack = 1'b1;
    tick(1);
    checkOutput("rst_first_grant", s_wb_addr, 8'h50);
    checkOutput("rst_drop_ack", ack_log.size(), 0);
    bus.i_wb_ack = 1'b0;
    bus.i_m_cyc  = '0;
    bus.i_m_stb  = '0;
    tick(2);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
